// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Instruction sequencer: holds the program counter, drives the instruction ROM
// address, registers the fetched word for the control decoder, redirects on
// taken branches and halts on the done opcode.
//
// Optional feature macro: FETCH_RETIRE_COUNT_EN
//   When defined, adds a saturating 16-bit retired-instruction counter.
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        synchronous active-high reset
//   start        one-cycle pulse, begins execution from START_ADDR (IDLE/HALT)
//   stall        hold all fetch state this cycle
//   branch_taken branch condition true for the word currently on instr
//   imem_addr    instruction ROM address (= pc)
//   imem_rdata   ROM word at imem_addr (combinational read)
//   instr        registered word to Control; opcode instr[8:5]
//   instr_pc     address instr was fetched from
//   instr_valid  instr is live and must execute
//   busy         high in RUN
//   done         high in HALT
//   retire_count (FETCH_RETIRE_COUNT_EN only) words executed since start
//
// State table:
//   state  | meaning
//   S_IDLE | waiting for start after reset
//   S_RUN  | fetching and presenting instructions
//   S_HALT | done opcode executed, waiting for a restart
module instr_fetch_unit #(
  parameter int          PC_WIDTH    = 10,
  parameter int          INSTR_WIDTH = 9,
  parameter int unsigned START_ADDR  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   branch_taken,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   done
`ifdef FETCH_RETIRE_COUNT_EN
  ,
  output logic [15:0]            retire_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(START_ADDR);

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [3:0]          opcode;
  logic [PC_WIDTH-1:0] br_off;
  logic [PC_WIDTH-1:0] br_target;
  logic                do_halt;
  logic                do_branch;

  assign imem_addr = pc;
  assign opcode    = instr[INSTR_WIDTH-1 -: 4];
  // 5-bit two's-complement offset, sign-extended; the add wraps mod 2^PC_WIDTH
  assign br_off    = {{(PC_WIDTH-5){instr[4]}}, instr[4:0]};
  assign br_target = instr_pc + br_off;
  // Only a live word can halt or redirect; halt and branch opcodes are disjoint
  assign do_halt   = instr_valid && (opcode == 4'b1111);
  assign do_branch = instr_valid && branch_taken &&
                     ((opcode == 4'b0001) || (opcode == 4'b0010) || (opcode == 4'b0011));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= START_PC;
      instr        <= '0;
      instr_pc     <= '0;
      instr_valid  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef FETCH_RETIRE_COUNT_EN
      retire_count <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state        <= S_RUN;
            pc           <= START_PC;
            instr_valid  <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
`ifdef FETCH_RETIRE_COUNT_EN
            retire_count <= '0;
`endif
          end
        end
        S_RUN: begin
          if (!stall) begin
`ifdef FETCH_RETIRE_COUNT_EN
            if (instr_valid && (retire_count != 16'hFFFF))
              retire_count <= retire_count + 16'd1;
`endif
            if (do_halt) begin
              state       <= S_HALT;
              instr_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              instr    <= imem_rdata;
              instr_pc <= pc;
              if (do_branch) begin
                // The sequential word captured this cycle becomes a bubble
                pc          <= br_target;
                instr_valid <= 1'b0;
              end else begin
                pc          <= pc + 1'b1;
                instr_valid <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int DEPTH = 1024;
  localparam int NMAX  = 200;

  logic       clk = 1'b0;
  logic       reset, start, stall, branch_taken;
  logic [9:0] imem_addr, instr_pc;
  logic [8:0] imem_rdata, instr;
  logic       instr_valid, busy, done;
`ifdef FETCH_RETIRE_COUNT_EN
  logic [15:0] retire_count;
`endif

  logic [8:0] rom [DEPTH];
  assign imem_rdata = rom[imem_addr];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .busy(busy), .done(done)
`ifdef FETCH_RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

  typedef struct { int pc; logic [8:0] w; } ret_t;
  ret_t       exp_q[$];
  logic [8:0] trace_w [NMAX];
  bit         take [NMAX];
  int         n_trace, halt_pc;
  int         retired_total = 0;
  bit         mon_en = 1'b0;
  int         n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic bit is_br(input logic [8:0] w);
    return (w[8:5] == 4'd1) || (w[8:5] == 4'd2) || (w[8:5] == 4'd3);
  endfunction

  // Reference: walk the program as an ISA-level interpreter. A run that does
  // not reach a halt gets a halt planted at its next address, which shortens
  // the identical replayed prefix to a halting trace.
  task automatic build_trace();
    int a, off, lim;
    bit halted;
    for (int pass = 0; pass < 2; pass++) begin
      a = 0; halted = 1'b0; n_trace = 0; exp_q.delete();
      lim = (pass == 0) ? NMAX - 1 : NMAX;
      while (!halted && n_trace < lim) begin
        ret_t r;
        r.pc = a; r.w = rom[a];
        exp_q.push_back(r);
        trace_w[n_trace] = rom[a];
        if (rom[a][8:5] == 4'hF) begin
          halted = 1'b1; halt_pc = a;
        end else if (is_br(rom[a]) && take[n_trace]) begin
          off = rom[a][4] ? int'(rom[a][4:0]) - 32 : int'(rom[a][4:0]);
          a = (a + off + DEPTH) % DEPTH;
        end else begin
          a = (a + 1) % DEPTH;
        end
        n_trace++;
      end
      if (halted) break;
      rom[a] = 9'h1E0;
    end
  endtask

  // Monitor: a word executes when it is valid and not stalled
  always begin
    @(negedge clk);
    #1;
    if (mon_en && instr_valid && !stall) begin
      if (exp_q.size() == 0) begin
        chk("extra_retire_pc", int'(instr_pc), -1);
      end else begin
        ret_t e;
        e = exp_q.pop_front();
        chk("retire_instr", int'(instr), int'(e.w));
        chk("retire_instr_pc", int'(instr_pc), e.pc);
        chk("retire_next_pc", int'(imem_addr), (e.pc + 1) % DEPTH);
      end
      retired_total++;
    end
  end

  task automatic fill_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = 9'($urandom);
  endtask

  task automatic clear_take();
    for (int i = 0; i < NMAX; i++) take[i] = 1'b0;
  endtask

  task automatic run_prog(input int stall_pct);
    int cyc, base, retired;
    build_trace();
    base = retired_total; retired = 0;
    mon_en = 1'b1;
    start = 1'b1; stall = 1'b0; branch_taken = 1'($urandom);
    @(negedge clk);
    start = 1'b0; stall = 1'b0; branch_taken = 1'($urandom);
    chk("start_busy", int'(busy), 1);
    chk("start_done", int'(done), 0);
    chk("start_valid", int'(instr_valid), 0);
    chk("start_pc", int'(imem_addr), 0);
    @(negedge clk);
    chk("first_word_latency", int'(instr_valid), 1);
    cyc = 0;
    while (!(retired == n_trace && done) && cyc < 3000) begin
      stall = ($urandom_range(99) < stall_pct);
      start = (retired < n_trace) && ($urandom_range(15) == 0);
      if (instr_valid && !stall && retired < n_trace)
        branch_taken = is_br(trace_w[retired]) ? take[retired] : 1'b1;
      else
        branch_taken = 1'($urandom);
      @(negedge clk);
      cyc++;
      retired = retired_total - base;
    end
    start = 1'b0; stall = 1'b0;
    chk("run_complete", retired, n_trace);
    chk("halt_done", int'(done), 1);
    chk("halt_busy", int'(busy), 0);
    chk("halt_valid", int'(instr_valid), 0);
    chk("halt_pc_frozen", int'(imem_addr), (halt_pc + 1) % DEPTH);
`ifdef FETCH_RETIRE_COUNT_EN
    chk("retire_count", int'(retire_count), n_trace);
`endif
    repeat (3) begin
      stall = 1'($urandom); branch_taken = 1'($urandom);
      @(negedge clk);
    end
    stall = 1'b0;
    chk("halt_hold_pc", int'(imem_addr), (halt_pc + 1) % DEPTH);
    chk("halt_hold_done", int'(done), 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    fill_rom(); clear_take();
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(instr_valid), 0);
    chk("rst_instr", int'(instr), 0);
    chk("rst_instr_pc", int'(instr_pc), 0);
    chk("rst_pc", int'(imem_addr), 0);
    reset = 1'b0;
    stall = 1'b1; branch_taken = 1'b1;
    repeat (2) @(negedge clk);
    stall = 1'b0; branch_taken = 1'b0;
    chk("idle_hold_busy", int'(busy), 0);

    // Straight-line program ending in halt
    fill_rom(); clear_take();
    rom[0] = 9'h0A0; rom[1] = 9'h100; rom[2] = 9'h140; rom[3] = 9'h1E0;
    run_prog(0);

    // Backward branch taken once, then not taken, with non-branch noise
    fill_rom(); clear_take();
    for (int i = 0; i < 5; i++) rom[i] = 9'h0A0;
    rom[3] = 9'h100;
    rom[5] = 9'h03C; rom[6] = 9'h0A0; rom[7] = 9'h1E0;
    take[5] = 1'b1;
    run_prog(0);
    run_prog(30);

    // Address wrap both ways
    fill_rom(); clear_take();
    rom[0] = 9'h03C; rom[1] = 9'h03C; rom[2] = 9'h1E0;
    for (int i = 1020; i < 1024; i++) rom[i] = 9'h0A0;
    take[0] = 1'b1; take[6] = 1'b1;
    run_prog(20);

    // Reset two cycles into RUN aborts
    mon_en = 1'b0;
    fill_rom(); clear_take();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_valid", int'(instr_valid), 0);
    chk("abort_pc", int'(imem_addr), 0);

    // Randomized programs and branch decisions
    for (int r = 0; r < 8; r++) begin
      fill_rom();
      for (int i = 0; i < NMAX; i++) take[i] = 1'($urandom_range(1));
      run_prog(25);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction sequencer that produces the 9-bit machine word consumed by the control decoder, and consumes the branch and done decisions that the decoder's opcode classes imply.
- Holds the program counter and drives the instruction-memory address.
- Registers the fetched word, redirects on taken branches, and halts on the done opcode.
- Sits between instruction ROM and the Control/ALU datapath; top level starts it with a start pulse.

Parameters:
- PC_WIDTH, 10, program counter / instruction-memory address width.
- INSTR_WIDTH, 9, machine word width; opcode = instr[8:5], branch offset = instr[4:0].
- START_ADDR, 0, pc value loaded on start.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse, begins execution from START_ADDR.
- stall  input  1  hold all fetch state this cycle.
- branch_taken  input  1  Branch control AND datapath condition true, for the word currently on instr.
- imem_addr  output  PC_WIDTH  instruction ROM address (= pc).
- imem_rdata  input  INSTR_WIDTH  ROM word at imem_addr, combinational read.
- instr  output  INSTR_WIDTH  registered word to Control; opcode instr[8:5].
- instr_pc  output  PC_WIDTH  address instr was fetched from.
- instr_valid  output  1  instr is live and must execute.
- busy  output  1  high in RUN.
- done  output  1  high in HALT.

Behaviour:
- States: IDLE, RUN, HALT.
- Reset: state=IDLE, pc=START_ADDR, instr=0, instr_pc=0, instr_valid=0, busy=0, done=0. Reset mid-RUN aborts immediately; no pending branch survives.
- IDLE: start=1 -> RUN, pc=START_ADDR, instr_valid=0. Otherwise hold.
- RUN with stall=1: pc, instr, instr_pc, instr_valid, state all hold. branch_taken and halt detection are ignored that cycle.
- RUN with stall=0, normal: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
- Latency: word at address A appears on instr one cycle after pc=A; the first valid instr comes 2 cycles after the start pulse.
- Branch: when instr_valid=1, opcode in {4'b0001,4'b0010,4'b0011}, branch_taken=1 and stall=0:
  - pc<=instr_pc+sext(instr[4:0]), range -16..+15.
  - instr_valid<=0: the sequential word fetched this cycle is squashed (one bubble).
  - The bubble holds instr data but is not valid; branch_taken while instr_valid=0 or on a non-branch opcode is ignored.
- Halt: instr_valid=1 and opcode 4'b1111 with stall=0 -> HALT, instr_valid<=0, pc holds, done<=1. Halt is checked before branch (mutually exclusive opcodes).
- HALT: done stays 1, busy=0. start=1 -> RUN from START_ADDR, done<=0.
- start while RUN is ignored.
- Arithmetic: pc+1 and branch targets wrap modulo 2^PC_WIDTH (0x3FF+1 -> 0x000; 0x002-4 -> 0x3FE).
- busy = (state==RUN); done = (state==HALT); both registered with the state.

Optional Feature:
- Macro FETCH_RETIRE_COUNT_EN.
- Defined: adds output retire_count [15:0], cleared on reset and on an accepted start. It increments each cycle instr_valid=1 and stall=0, including branch and halt words, and saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then start at cycle 0, ROM[0..3]={0x0A0,0x100,0x140,0x1E0}, no stall -> instr 0x0A0,0x100,0x140 valid on cycles 2,3,4; 0x1E0 valid cycle 5; done=1 from cycle 6; pc frozen at 4.
- ROM[5]=0x03C (opcode 0001, offset -4), branch_taken=1 while instr_pc=5 -> next pc=1; the word from address 6 is squashed (instr_valid=0 one cycle); instr_pc=1 valid next.
- Same branch opcode with branch_taken=0 -> sequential fetch continues, no bubble; branch_taken=1 on opcode 1000 -> ignored.
- stall high for 3 cycles mid-run, with branch_taken pulsed during the stall -> instr, instr_pc and pc unchanged for 3 cycles; branch not taken; resumes exactly where it left off.
- pc=0x3FF fetch -> next pc=0x000. Branch at instr_pc=0x001 with offset 0x1C (-4) -> pc=0x3FD.
- reset asserted 2 cycles into RUN -> next cycle IDLE, instr_valid=0, done=0. A start in HALT restarts at 0 with done cleared. With FETCH_RETIRE_COUNT_EN defined, the first scenario ends with retire_count=4.
